// File: rtl/scaledclk_monitor.sv
`timescale 1ns/1ps
// Purpose : qualifies a slow divided clock; emits a tick per rising edge, measures its period, tracks lock/loss.
// Latency : tick and status are registered; they appear two system clocks after the first high sample of the input.
// Backpr. : none; i_enable freezes counting and state (tick forced low); the synchronizer always runs.
//
// Ports:
//   i_clk            system clock, all logic on the rising edge
//   i_rst_n          asynchronous active-low reset
//   i_enable         run/freeze control
//   i_scaledclk_in   slow clock, asynchronous to i_clk
//   o_tick           one-cycle pulse per accepted rising edge
//   o_period         last measured edge-to-edge period, in enabled clock cycles
//   o_period_valid   a period has been measured since IDLE or LOST
//   o_locked         LOCKED state
//   o_lost           LOST state
//   o_err_count      out-of-tolerance periods seen while locked, saturating at 255
module scaledclk_monitor #(
  parameter int NOMINAL_PERIOD = 200,
  parameter int TOLERANCE      = 4,
  parameter int LOCK_EDGES     = 2,
  parameter int TIMEOUT        = 400,
  parameter int CNT_W          = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_scaledclk_in,
  output logic             o_tick,
  output logic [CNT_W-1:0] o_period,
  output logic             o_period_valid,
  output logic             o_locked,
  output logic             o_lost,
  output logic [7:0]       o_err_count
);

  localparam int GOOD_W = (LOCK_EDGES < 2) ? 1 : $clog2(LOCK_EDGES + 1);
  localparam logic [CNT_W-1:0] P_LO      = CNT_W'(NOMINAL_PERIOD - TOLERANCE);
  localparam logic [CNT_W-1:0] P_HI      = CNT_W'(NOMINAL_PERIOD + TOLERANCE);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_EDGES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACQUIRE,
    ST_LOCKED,
    ST_LOST
  } state_t;

  // Synchronizer pair plus history flop; free-running regardless of i_enable.
  logic r_s1, r_s2, r_s3;

  logic [CNT_W-1:0]  r_cnt;
  logic [GOOD_W-1:0] r_good;
  state_t            r_state;
  logic              r_tick;
  logic [CNT_W-1:0]  r_period;
  logic              r_period_valid;
  logic              r_locked;
  logic              r_lost;
  logic [7:0]        r_err_count;

  logic              w_rise;
  logic              w_acc;
  logic [CNT_W-1:0]  w_meas;
  logic              w_in_tol;
  logic [GOOD_W-1:0] w_good_inc;
  logic              w_timeout;

  assign w_rise     = r_s2 & ~r_s3;
  assign w_acc      = w_rise & i_enable;
  // cnt restarts at 0 on an edge, so the edge-to-edge distance is cnt+1.
  assign w_meas     = r_cnt + CNT_W'(1);
  assign w_in_tol   = (w_meas >= P_LO) && (w_meas <= P_HI);
  assign w_good_inc = r_good + GOOD_W'(1);
  // Only a missing edge times out; an edge landing on the threshold wins.
  assign w_timeout  = i_enable && !w_acc && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_scaledclk_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_acc) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // FSM with registered status outputs; everything holds while i_enable is low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= ST_IDLE;
      r_good         <= '0;
      r_tick         <= 1'b0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_locked       <= 1'b0;
      r_lost         <= 1'b0;
      r_err_count    <= '0;
    end else begin
      r_tick <= w_acc;
      case (r_state)
        ST_IDLE: begin
          // First edge only establishes the reference; nothing to measure yet.
          if (w_acc) r_state <= ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          if (w_acc) begin
            r_period       <= w_meas;
            r_period_valid <= 1'b1;
            if (w_in_tol) begin
              if (w_good_inc == GOOD_LOCK) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
                r_good   <= '0;
              end else begin
                r_good <= w_good_inc;
              end
            end else begin
              r_good <= '0;
            end
          end else if (w_timeout) begin
            r_state        <= ST_LOST;
            r_lost         <= 1'b1;
            r_period_valid <= 1'b0;
            r_good         <= '0;
          end
        end
        ST_LOCKED: begin
          if (w_acc) begin
            r_period <= w_meas;
            if (!w_in_tol) begin
              if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
              r_state  <= ST_ACQUIRE;
              r_locked <= 1'b0;
            end
          end else if (w_timeout) begin
            r_state        <= ST_LOST;
            r_lost         <= 1'b1;
            r_locked       <= 1'b0;
            r_period_valid <= 1'b0;
            r_good         <= '0;
          end
        end
        ST_LOST: begin
          // The stale reference is discarded: this edge becomes the new one.
          if (w_acc) begin
            r_state <= ST_ACQUIRE;
            r_lost  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_tick         = r_tick;
  assign o_period       = r_period;
  assign o_period_valid = r_period_valid;
  assign o_locked       = r_locked;
  assign o_lost         = r_lost;
  assign o_err_count    = r_err_count;

endmodule

// File: tb/tb_scaledclk_monitor.sv
`timescale 1ns/1ps
// Purpose : randomized bench for scaledclk_monitor against an event-level reference model.
// Latency : model predicts tick two clocks after the first high sample of the slow clock.
// Backpr. : enable windows are driven from the stimulus; the model accounts frozen cycles.
module tb_scaledclk_monitor;

  localparam int NP  = 200;
  localparam int TOL = 4;
  localparam int LE  = 2;
  localparam int TO  = 400;
  localparam int CW  = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          sin;
  logic          tick;
  logic [CW-1:0] period;
  logic          period_valid;
  logic          locked;
  logic          lost;
  logic [7:0]    err_count;

  scaledclk_monitor #(
    .NOMINAL_PERIOD(NP), .TOLERANCE(TOL), .LOCK_EDGES(LE), .TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_scaledclk_in(sin),
    .o_tick(tick), .o_period(period), .o_period_valid(period_valid),
    .o_locked(locked), .o_lost(lost), .o_err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_ACQ, M_LOCK, M_LOST} mstate_t;
  mstate_t m_st;
  int      m_good, m_since, m_period, m_err;
  bit      m_pv, m_tick;
  bit      m_prev, m_q1, m_q2;   // sample history and the two-clock tick delay

  task automatic model_reset();
    m_st = M_IDLE; m_good = 0; m_since = 0; m_period = 0; m_err = 0;
    m_pv = 0; m_tick = 0; m_prev = 0; m_q1 = 0; m_q2 = 0;
  endtask

  initial model_reset();

  bit samp, rise, fire, acc, good_p;
  int meas;
  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      samp   = sin;
      rise   = samp && !m_prev;
      m_prev = samp;
      fire   = m_q2;
      m_q2   = m_q1;
      m_q1   = rise;
      acc    = fire && en;
      m_tick = acc;
      // enabled cycles elapsed since the last accepted edge
      if (en && m_since < (1 << CW) - 1) m_since++;
      meas = m_since;
      if (acc) begin
        m_since = 0;
        good_p  = (meas >= NP - TOL) && (meas <= NP + TOL);
        case (m_st)
          M_IDLE: m_st = M_ACQ;
          M_ACQ: begin
            m_period = meas;
            m_pv     = 1;
            if (good_p) begin
              m_good++;
              if (m_good == LE) begin m_st = M_LOCK; m_good = 0; end
            end else m_good = 0;
          end
          M_LOCK: begin
            m_period = meas;
            if (!good_p) begin
              if (m_err < 255) m_err++;
              m_st = M_ACQ;
            end
          end
          M_LOST: m_st = M_ACQ;
        endcase
      end else if (en && (m_st == M_ACQ || m_st == M_LOCK) && m_since == TO) begin
        m_st = M_LOST; m_pv = 0; m_good = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on && rst_n) begin
      chk("tick",         tick,         m_tick);
      chk("period",       period,       m_period);
      chk("period_valid", period_valid, m_pv);
      chk("locked",       locked,       m_st == M_LOCK);
      chk("lost",         lost,         m_st == M_LOST);
      chk("err_count",    err_count,    m_err);
    end
  end

  // ---------------- stimulus ----------------
  // One slow-clock period of n cycles starting with a rising edge; enable low in [off_s, off_s+off_l).
  task automatic run_period(input int n, input int off_s = -1, input int off_l = 0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sin = (i < n / 2);
      en  = !(i >= off_s && i < off_s + off_l);
    end
  endtask

  task automatic hold(input bit level, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sin = level;
      en  = 1'b1;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_tick"},   tick,         0);
    chk({tag, "_period"}, period,       0);
    chk({tag, "_pv"},     period_valid, 0);
    chk({tag, "_locked"}, locked,       0);
    chk({tag, "_lost"},   lost,         0);
    chk({tag, "_err"},    err_count,    0);
  endtask

  // Reset asserted between clock edges; outputs must clear before the next edge.
  task automatic pulse_reset();
    @(negedge clk);
    sin = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_zero("rst_async");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    sin   = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("rst");
    #2 rst_n = 1'b1;
    en     = 1'b1;
    chk_on = 1'b1;

    // nominal lock
    repeat (4) run_period(200);
    chk("nom_locked", locked, 1);
    chk("nom_err", err_count, 0);

    // tolerance boundary, then relock
    run_period(196);
    run_period(204);
    run_period(195);
    repeat (4) run_period(200);
    chk("tol_relock", locked, 1);
    chk("tol_err", err_count, 1);

    // loss and recovery
    hold(1'b1, 450);
    chk("loss_lost", lost, 1);
    chk("loss_locked", locked, 0);
    chk("loss_pv", period_valid, 0);
    hold(1'b0, 20);
    repeat (4) run_period(200);
    chk("loss_relock", locked, 1);

    // enable gating: frozen window without an edge, then a dropped edge
    run_period(200, 120, 50);
    repeat (4) run_period(200);
    run_period(200, 0, 6);
    repeat (4) run_period(200);

    // randomized periods and enable windows
    for (int k = 0; k < 30; k++) begin
      int p, os, ol;
      p  = ($urandom % 4 == 0) ? $urandom_range(260, 150) : $urandom_range(204, 196);
      os = -1;
      ol = 0;
      if ($urandom % 5 == 0) begin
        os = $urandom_range(p - 60, p / 2 + 2);
        ol = $urandom_range(40, 1);
      end
      run_period(p, os, ol);
    end

    // reset in ACQUIRE after two ticks
    pulse_reset();
    repeat (2) run_period(200);
    pulse_reset();
    repeat (4) run_period(200);
    chk("rst_relock", locked, 1);

    // edge exactly at the timeout threshold while acquiring
    run_period(150);
    run_period(400);
    run_period(200);
    chk("thr_lost", lost, 0);
    chk("thr_period", period, 400);
    chk("thr_locked", locked, 0);
    repeat (3) run_period(200);

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
